// File: rtl/display_pkg.sv
// Shared constants and types for the image-ROM read path.
package display_pkg;

  localparam int ROM_DEPTH  = 4800;
  localparam int ROM_ADDR_W = 13;
  localparam int PIX_W      = 24;

  localparam logic CLI_DISP = 1'b0;
  localparam logic CLI_AUX  = 1'b1;

  // Travels with each grant so the returning word can be steered one cycle later.
  typedef struct packed {
    logic valid;
    logic owner;
    logic oor;
  } rsp_tag_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector with an urgent override for client 0 and a
// starvation override for client 1. Purely combinational.
module rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_urgent0,
  input  logic i_wait_max,
  input  logic i_last_gnt,
  output logic o_gnt0,
  output logic o_gnt1
);

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_req0 && i_urgent0) begin
      o_gnt0 = 1'b1;
    end else if (i_req1 && i_wait_max) begin
      o_gnt1 = 1'b1;
    end else if (i_req0 && i_req1) begin
      // i_last_gnt high means client 1 went last, so client 0 takes the tie.
      if (i_last_gnt) o_gnt0 = 1'b1;
      else            o_gnt1 = 1'b1;
    end else if (i_req0) begin
      o_gnt0 = 1'b1;
    end else if (i_req1) begin
      o_gnt1 = 1'b1;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single image-ROM read port between the display fetcher (client 0)
// and a secondary reader (client 1); routes each returning word to its owner.
module rom_port_arbiter
  import display_pkg::*;
#(
  parameter int ADDR_W   = ROM_ADDR_W,
  parameter int DATA_W   = PIX_W,
  parameter int DEPTH    = ROM_DEPTH,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              urgent0,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [15:0]       gcnt0,
  output logic [15:0]       gcnt1
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(DEPTH);

  logic              r_last_gnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [15:0]       r_gcnt0;
  logic [15:0]       r_gcnt1;
  rsp_tag_t          r_tag;

  logic              w_wait_max;
  logic              w_any_gnt;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_addr_sel;

  assign w_wait_max = (r_wait_cnt == WAIT_SAT);

  rr_pick2 u_pick (
    .i_req0     (req0),
    .i_req1     (req1),
    .i_urgent0  (urgent0),
    .i_wait_max (w_wait_max),
    .i_last_gnt (r_last_gnt),
    .o_gnt0     (gnt0),
    .o_gnt1     (gnt1)
  );

  assign w_any_gnt  = gnt0 | gnt1;
  assign w_addr_sel = gnt1 ? addr1 : addr0;
  assign w_in_range = ({1'b0, w_addr_sel} < ADDR_LIM);

  // Out-of-range grants never touch the ROM; they are answered with an error.
  assign rom_rd   = w_any_gnt && w_in_range;
  assign rom_addr = rom_rd ? w_addr_sel : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
      r_wait_cnt <= '0;
      r_gcnt0    <= '0;
      r_gcnt1    <= '0;
      r_tag      <= '0;
    end else begin
      if (w_any_gnt) r_last_gnt <= gnt1;

      if (!req1 || gnt1)              r_wait_cnt <= '0;
      else if (r_wait_cnt != WAIT_SAT) r_wait_cnt <= r_wait_cnt + 1'b1;

      if (gnt0 && (r_gcnt0 != 16'hFFFF)) r_gcnt0 <= r_gcnt0 + 16'd1;
      if (gnt1 && (r_gcnt1 != 16'hFFFF)) r_gcnt1 <= r_gcnt1 + 16'd1;

      r_tag.valid <= w_any_gnt;
      r_tag.owner <= gnt1 ? CLI_AUX : CLI_DISP;
      r_tag.oor   <= w_any_gnt && !w_in_range;
    end
  end

  assign rvalid0 = r_tag.valid && (r_tag.owner == CLI_DISP);
  assign rvalid1 = r_tag.valid && (r_tag.owner == CLI_AUX);
  assign err0    = rvalid0 && r_tag.oor;
  assign err1    = rvalid1 && r_tag.oor;
  assign rdata0  = (rvalid0 && !r_tag.oor) ? rom_data : '0;
  assign rdata1  = (rvalid1 && !r_tag.oor) ? rom_data : '0;
  assign gcnt0   = r_gcnt0;
  assign gcnt1   = r_gcnt1;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: directed steps push expected
// responses, an independent monitor pops and checks them.
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        urgent0, req0, req1;
  logic [12:0] addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, rom_rd;
  logic [23:0] rdata0, rdata1, rom_data;
  logic [12:0] rom_addr;
  logic [15:0] gcnt0, gcnt1;

  always #5 clk = ~clk;

  rom_port_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .urgent0  (urgent0),
    .req0     (req0),
    .req1     (req1),
    .addr0    (addr0),
    .addr1    (addr1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .err0     (err0),
    .err1     (err1),
    .rom_rd   (rom_rd),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .gcnt0    (gcnt0),
    .gcnt1    (gcnt1)
  );

  typedef struct {
    logic        owner;
    logic [23:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic logic [23:0] rom_f(input logic [12:0] a);
    return {a[7:0] ^ 8'hA5, 3'b000, a};
  endfunction

  // Behavioural ROM: one-cycle registered read, garbage when not strobed.
  always @(posedge clk) begin
    rom_data <= rom_rd ? rom_f(rom_addr) : 24'hBADBAD;
    cyc      <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests, check the combinational grant and ROM strobe,
  // and queue the response expected one cycle later.
  task automatic step(input logic r0, input logic [12:0] a0,
                      input logic r1, input logic [12:0] a1,
                      input logic u, input logic eg0, input logic eg1,
                      input string tag);
    logic [12:0] sel;
    logic        inr, erd;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; urgent0 = u;
    @(negedge clk);
    chk({tag, " gnt"}, {30'd0, gnt1, gnt0}, {30'd0, eg1, eg0});
    sel = eg1 ? a1 : a0;
    inr = (sel < 13'd4800);
    erd = (eg0 | eg1) && inr;
    chk({tag, " rom"}, {18'd0, rom_rd, rom_addr}, {18'd0, erd, (erd ? sel : 13'd0)});
    if (eg0 | eg1)
      q.push_back('{owner: eg1, data: (inr ? rom_f(sel) : 24'd0), err: !inr, due: cyc + 1});
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 13'd0, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (rvalid0 || rvalid1)) begin
        if (q.size() == 0) begin
          chk("spurious rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp latency", cyc, e.due);
          chk("rsp flags", {28'd0, rvalid1, rvalid0, err1, err0},
              {28'd0, e.owner, !e.owner, e.owner & e.err, !e.owner & e.err});
          chk("rsp data", {8'd0, (e.owner ? rdata1 : rdata0)}, {8'd0, e.data});
          chk("rsp other data", {8'd0, (e.owner ? rdata0 : rdata1)}, 32'd0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; urgent0 = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", {4'd0, rvalid1, rvalid0, err1, err0, rdata1}, 32'd0);
    chk("reset rdata0", {8'd0, rdata0}, 32'd0);
    chk("reset gcnt", {gcnt1, gcnt0}, 32'd0);
    rst_n = 1'b1;

    // Lone client 0 on consecutive cycles.
    step(1, 13'd0,  0, 13'd0, 0, 1, 0, "t1 a0");
    step(1, 13'd1,  0, 13'd0, 0, 1, 0, "t1 a1");
    step(1, 13'd79, 0, 13'd0, 0, 1, 0, "t1 a79");
    idle("t1 idle");
    chk("t1 gcnt0", {16'd0, gcnt0}, 32'd3);

    // Reset asserted while a response is in flight.
    req0 = 1'b1; addr0 = 13'd5; req1 = 1'b0; urgent0 = 1'b0;
    @(negedge clk);
    chk("rst gnt", {30'd0, gnt1, gnt0}, 32'd1);
    rst_n = 1'b0; req0 = 1'b0;
    @(posedge clk); #1;
    chk("rst rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    rst_n = 1'b1;
    idle("rst idle0");
    idle("rst idle1");
    chk("rst counters", {gcnt1, gcnt0}, 32'd0);
    chk("rst wait_cnt", {28'd0, dut.r_wait_cnt}, 32'd0);

    // Both requesting, round-robin starting with client 0.
    step(1, 13'd10, 1, 13'd20, 0, 1, 0, "t2 c0");
    step(1, 13'd11, 1, 13'd20, 0, 0, 1, "t2 c1");
    step(1, 13'd11, 1, 13'd21, 0, 1, 0, "t2 c0b");
    step(1, 13'd12, 1, 13'd21, 0, 0, 1, "t2 c1b");
    idle("t2 idle");

    // Urgent client 0 holds off client 1 until urgency drops.
    for (int i = 0; i < 20; i++)
      step(1, 13'(100 + i), 1, 13'd200, 1, 1, 0, "t3 urgent");
    chk("t3 wait sat", {28'd0, dut.r_wait_cnt}, 32'd8);
    step(1, 13'd120, 1, 13'd200, 0, 0, 1, "t3 starve");
    step(1, 13'd120, 1, 13'd201, 0, 1, 0, "t3 rr0");
    step(1, 13'd121, 1, 13'd201, 0, 0, 1, "t3 rr1");
    idle("t3 idle");
    chk("t3 wait clr", {28'd0, dut.r_wait_cnt}, 32'd0);

    // Address range boundaries.
    step(0, 13'd0,    1, 13'd4800, 0, 0, 1, "t4 oor1");
    step(0, 13'd0,    1, 13'd4799, 0, 0, 1, "t4 last1");
    step(1, 13'd8191, 0, 13'd0,    0, 1, 0, "t4 oor0");
    idle("t4 idle");

    // Grant counter saturation.
    for (int i = 0; i < 70000; i++)
      step(1, 13'(i % 4800), 0, 13'd0, 0, 1, 0, "t5 sat");
    idle("t5 idle");
    chk("t5 gcnt0 sat", {16'd0, gcnt0}, 32'h0000FFFF);
    chk("t5 gcnt1", {16'd0, gcnt1}, 32'd6);

    idle("end idle");
    chk("queue drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single read port of the 80x60 image ROM (4800 words x 24 bit, one-cycle registered read) between two read clients. Client 0 is the display-plane fetcher feeding the pixel FIFO; client 1 is a secondary reader, such as the sprite/overlay fetcher or a debug readback. The block sits between the clients and the ROM. It grants one request per cycle and routes each returning word to its owner. It also guarantees that client 0 is never starved while the pixel FIFO is empty, and that client 1 is never starved otherwise.

## Interface
Parameters:
- ADDR_W, 13: ROM address width.
- DATA_W, 24: ROM data width (RGB888).
- DEPTH, 4800: number of valid ROM words.
- MAX_WAIT, 8: cycles client 1 may wait before it is forced ahead of round-robin.

Ports:
- clk, input, 1: single clock; all state on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- urgent0, input, 1: client 0 is urgent; tie to pixel FIFO fifo_empty.
- req0 / req1, input, 1: read request; held with address stable until the matching gnt.
- addr0 / addr1, input, ADDR_W: read address.
- gnt0 / gnt1, output, 1: combinational grant; request is consumed in this cycle.
- rvalid0 / rvalid1, output, 1: registered; read data valid for that client.
- rdata0 / rdata1, output, DATA_W: returned word; 0 when the matching rvalid is low.
- err0 / err1, output, 1: registered; asserts with rvalid when the granted address was >= DEPTH.
- rom_rd, output, 1: ROM read strobe.
- rom_addr, output, ADDR_W: ROM address; 0 when rom_rd is low.
- rom_data, input, DATA_W: ROM output, valid the cycle after rom_rd.
- gcnt0 / gcnt1, output, 16: saturating count of grants per client.

## Operation
Grant selection is combinational and evaluated every cycle. At most one gnt is high per cycle. The winner is the first matching rule:
1. req0 && urgent0 → client 0.
2. req1 && wait_cnt == MAX_WAIT → client 1.
3. Both requesting → the client not in last_gnt (round-robin).
4. Exactly one requesting → that client.
5. Otherwise no grant.

State and counters:
- last_gnt (1 bit): updates to the winner on every grant.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - increments when req1 && !gnt1, saturating at MAX_WAIT;
  - clears on gnt1 or !req1.
- gcnt0 / gcnt1: increment on the matching gnt and saturate at 16'hFFFF.

ROM access and response path:
- rom_rd = gnt0|gnt1 && addr_sel < DEPTH.
- rom_addr = the selected address when rom_rd is high, else 0.
- Out-of-range grant: no ROM access; response rdata = 0 and err = 1.
- Response tag registers {valid, owner, oor} on every grant.
- Next cycle: rvalid[owner] = 1, err[owner] = oor.
- rdata[owner] = oor ? 0 : rom_data.

## Timing
- Grant-to-data latency: exactly 1 cycle.
- Throughput: one grant per cycle. Back-to-back grants to the same or alternating clients are legal.
- Clients may drop req without a grant; no state is held for them except wait_cnt clearing.
- Simultaneous urgent0 and client 1 at MAX_WAIT: client 0 wins. wait_cnt stays at MAX_WAIT, and client 1 wins the first cycle urgent0 or req0 is low.
- Reset values:
  - rvalid*, err* = 0 and rdata* = 0;
  - gcnt* = 0, wait_cnt = 0;
  - last_gnt = 1, so client 0 wins the first tie.
- Reset asserted mid-read: the in-flight response is dropped, and no rvalid follows reset release.
- gnt*, rom_rd and rom_addr follow the reset-state inputs combinationally.

## Structure
- Shared package (display_pkg): ROM_DEPTH = 4800, ROM_ADDR_W = 13, PIX_W = 24, and client index constants CLI_DISP = 0, CLI_AUX = 1.
- Sub-module: rr_pick2, the pure combinational two-way round-robin selector with priority overrides. Everything else stays in the top module.

## Test plan
- Lone client 0 reads addr 0, 1, 79 on consecutive cycles:
  - gnt0 each cycle;
  - rvalid0 one cycle later with the matching ROM words;
  - gcnt0 = 3.
- Both request continuously, urgent0 = 0 after reset: grants alternate 0,1,0,1; each rvalid goes to the correct client with the correct data.
- urgent0 = 1 and both request for 20 cycles:
  - gnt0 every cycle;
  - wait_cnt saturates at 8;
  - urgent0 drops → gnt1 on the next cycle, then round-robin resumes.
- Client 1 request at addr 4800: gnt1, rom_rd = 0; next cycle rvalid1 = 1, err1 = 1, rdata1 = 0.
- rst_n pulsed low the cycle after gnt0: no rvalid0 appears; all counters read 0 after release.
- 70000 grants to client 0: gcnt0 holds 16'hFFFF.
